// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, default bus timing and idle line levels for the RTC bus-cycle generator.
package rtc_bus_pkg;
  typedef enum logic [2:0] {IDLE, ADR_SU, ADR_PW, ADR_H, DAT_SU, DAT_PW, DAT_H, REC} state_t;
  localparam int T_SU_DEF = 2;
  localparam int T_PW_DEF = 8;
  localparam int T_H_DEF = 2;
  localparam int T_REC_DEF = 11;
  localparam logic A_D_IDLE = 1'b1;
  localparam logic CS_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  typedef struct packed {
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       send_add;
    logic       send_data;
    logic       read_data;
    logic       busy;
  } bus_t;
  localparam bus_t BUS_IDLE = '{a_d: A_D_IDLE, cs: CS_IDLE, rd: RD_IDLE, wr: WR_IDLE, default: '0};
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: 4-bit loadable down-counter with terminal count, shared by every bus phase.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic       tc_o
);
  logic [3:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
  end
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: multiplexed A/D bus-cycle generator for the RTC (address phase then write/read data phase).
// Define RTC_BUS_INSYNC_EN to synchronize ad_in and capture read data on the last DAT_H edge.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_H   = T_H_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it,
  input  logic       w_r,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       send_add,
  output logic       send_data,
  output logic       read_data,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done
);
  state_t state_q, state_d;
  bus_t bus_q, bus_d;
  logic tc, start, adr_ph, dat_ph, cap;
  logic [3:0] ld_val;
  logic w_r_q, w_r_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, ad_s, rdata_q;
  logic rdata_valid_q, done_q;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = do_it ? ADR_SU : IDLE;
      ADR_SU:  state_d = tc ? ADR_PW : ADR_SU;
      ADR_PW:  state_d = tc ? ADR_H : ADR_PW;
      ADR_H:   state_d = tc ? DAT_SU : ADR_H;
      DAT_SU:  state_d = tc ? DAT_PW : DAT_SU;
      DAT_PW:  state_d = tc ? DAT_H : DAT_PW;
      DAT_H:   state_d = tc ? REC : DAT_H;
      default: state_d = !tc ? REC : do_it ? ADR_SU : IDLE;
    endcase
  end
  assign ld_val = (state_d inside {ADR_SU, DAT_SU}) ? 4'(T_SU - 1) :
                  (state_d inside {ADR_PW, DAT_PW}) ? 4'(T_PW - 1) :
                  (state_d inside {ADR_H, DAT_H})   ? 4'(T_H - 1)  : 4'(T_REC - 1);
  rtc_phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (state_d != state_q),
    .val_i  (ld_val),
    .tc_o   (tc)
  );
  // Request fields are captured on the edge that enters ADR_SU, whether from IDLE or a back-to-back REC.
  assign start   = state_d == ADR_SU && state_q != ADR_SU;
  assign w_r_d   = start ? w_r : w_r_q;
  assign addr_d  = start ? addr : addr_q;
  assign wdata_d = start ? wdata : wdata_q;
  assign adr_ph  = state_d inside {ADR_SU, ADR_PW, ADR_H};
  assign dat_ph  = state_d inside {DAT_SU, DAT_PW, DAT_H};
  always_comb begin
    bus_d           = BUS_IDLE;
    bus_d.a_d       = adr_ph ? 1'b0 : A_D_IDLE;
    bus_d.cs        = (state_d == ADR_PW || state_d == DAT_PW) ? 1'b0 : CS_IDLE;
    bus_d.wr        = (state_d == ADR_PW || (state_d == DAT_PW && w_r_d)) ? 1'b0 : WR_IDLE;
    bus_d.rd        = (state_d == DAT_PW && !w_r_d) ? 1'b0 : RD_IDLE;
    bus_d.ad_oe     = adr_ph || (dat_ph && w_r_d);
    bus_d.ad_out    = adr_ph ? addr_d : (dat_ph && w_r_d) ? wdata_d : '0;
    bus_d.send_add  = adr_ph;
    bus_d.send_data = dat_ph && w_r_d;
    bus_d.read_data = dat_ph && !w_r_d;
    bus_d.busy      = state_d != IDLE;
  end
`ifdef RTC_BUS_INSYNC_EN
  logic [7:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) {sync1_q, sync2_q} <= '0;
    else {sync1_q, sync2_q} <= {ad_in, sync1_q};
  end
  assign ad_s = sync2_q;
  assign cap  = state_q == DAT_H && tc && !w_r_q;
`else
  assign ad_s = ad_in;
  assign cap  = state_q == DAT_PW && tc && !w_r_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q         <= BUS_IDLE;
      {w_r_q, addr_q, wdata_q, rdata_q} <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      bus_q         <= bus_d;
      w_r_q         <= w_r_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= cap ? ad_s : rdata_q;
      rdata_valid_q <= cap;
      done_q        <= state_d == REC && state_q != REC;
    end
  end
  assign {a_d, cs, rd, wr, ad_oe, ad_out, send_add, send_data, read_data, busy} = bus_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb_rtc_bus_cycle: table-driven transactions checked cycle by cycle through an expected-output queue.
module tb_rtc_bus_cycle;
  typedef struct packed {
    logic       a_d, cs, rd, wr, ad_oe;
    logic [7:0] ad_out;
    logic       send_add, send_data, read_data, busy, done, rdata_valid;
    logic [7:0] rdata;
  } out_t;
  typedef struct packed {
    logic       w_r;
    logic [7:0] addr, wdata, din, exp_rdata;
  } txn_t;
`ifdef RTC_BUS_INSYNC_EN
  localparam int CAP = 25;
`else
  localparam int CAP = 23;
`endif
  logic clk = 0, reset = 1, do_it = 0, w_r = 0;
  logic [7:0] addr = 0, wdata = 0, ad_in = 0;
  logic [7:0] ad_out, rdata;
  logic ad_oe, a_d, cs, rd, wr, send_add, send_data, read_data, rdata_valid, busy, done;
  out_t act, sb[$];
  logic [7:0] rdata_m = 0;
  int n_vec = 0, n_err = 0;
  txn_t tv[6];
  rtc_bus_cycle dut (
    .clk(clk), .reset(reset), .do_it(do_it), .w_r(w_r), .addr(addr), .wdata(wdata),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .send_add(send_add), .send_data(send_data), .read_data(read_data), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign act = {a_d, cs, rd, wr, ad_oe, ad_out, send_add, send_data, read_data, busy, done, rdata_valid, rdata};

  function automatic out_t exp_at(int c, txn_t t, logic [7:0] rp);
    out_t e;
    bit ap = c >= 1 && c <= 12;
    bit dp = c >= 13 && c <= 24;
    bit pw = (c >= 3 && c <= 10) || (c >= 15 && c <= 22);
    e.a_d = !ap;
    e.cs = !pw;
    e.wr = !(pw && (ap || t.w_r));
    e.rd = !(pw && dp && !t.w_r);
    e.ad_oe = ap || (dp && t.w_r);
    e.ad_out = ap ? t.addr : (dp && t.w_r) ? t.wdata : 8'h00;
    e.send_add = ap;
    e.send_data = dp && t.w_r;
    e.read_data = dp && !t.w_r;
    e.busy = c >= 1 && c <= 35;
    e.done = c == 25;
    e.rdata_valid = !t.w_r && c == CAP;
    e.rdata = (!t.w_r && c >= CAP && c <= 36) ? t.din : rp;
    return e;
  endfunction

  task automatic chk(input string nm);
    out_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s got=%h required=<scoreboard empty>", nm, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s got=%h required=%h", nm, act, e);
      end
    end
  endtask

  task automatic run_txn(input txn_t t, input int hold);
    @(negedge clk);
    do_it = 1; w_r = t.w_r; addr = t.addr; wdata = t.wdata; ad_in = 8'hA5;
    sb.push_back(exp_at(1, t, rdata_m));
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      chk($sformatf("txn_a%02h_c%0d", t.addr, c));
      do_it = c < hold; w_r = ~t.w_r; addr = ~t.addr; wdata = ~t.wdata;
      ad_in = (!t.w_r && c >= 15 && c <= 24) ? t.din : 8'(8'hA5 ^ c);
      if (c < 36) sb.push_back(exp_at(c + 1, t, rdata_m));
    end
    do_it = 0;
    rdata_m = t.exp_rdata;
  endtask

  function automatic out_t b2b_exp(int g, logic [7:0] rp);
    txn_t t;
    int k = (g - 1) / 35;
    t = '{w_r: 1'b1, addr: 8'(8'h40 + k), wdata: 8'(8'h80 + k), din: 8'h00, exp_rdata: rp};
    return g > 350 ? exp_at(36, t, rp) : exp_at((g - 1) % 35 + 1, t, rp);
  endfunction

  task automatic run_b2b();
    int dones = 0;
    @(negedge clk);
    do_it = 1; w_r = 1; addr = 8'h40; wdata = 8'h80;
    sb.push_back(b2b_exp(1, rdata_m));
    for (int g = 1; g <= 351; g++) begin
      @(negedge clk);
      chk($sformatf("b2b_g%0d", g));
      if (done) dones++;
      do_it = g < 350; addr = 8'(8'h40 + g / 35); wdata = 8'(8'h80 + g / 35);
      if (g < 351) sb.push_back(b2b_exp(g + 1, rdata_m));
    end
    n_vec++;
    if (dones != 10) begin
      n_err++;
      $display("FAIL b2b_done_count got=%0d required=10", dones);
    end
  endtask

  task automatic run_reset_abort();
    txn_t t = '{w_r: 1'b1, addr: 8'h5A, wdata: 8'h3C, din: 8'h00, exp_rdata: 8'h00};
    @(negedge clk);
    do_it = 1; w_r = 1; addr = t.addr; wdata = t.wdata;
    sb.push_back(exp_at(1, t, rdata_m));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk($sformatf("rst_c%0d", c));
      do_it = 0;
      reset = c == 17;
      sb.push_back(c + 1 <= 17 ? exp_at(c + 1, t, rdata_m) : exp_at(0, t, 8'h00));
    end
    void'(sb.pop_front());
    rdata_m = 8'h00;
  endtask

  initial begin
    txn_t t0 = '0;
    tv[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 8'h00};
    tv[1] = '{1'b0, 8'h22, 8'h00, 8'h59, 8'h59};
    tv[2] = '{1'b1, 8'h3C, 8'hA7, 8'h00, 8'h59};
    tv[3] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
    tv[4] = '{1'b0, 8'h00, 8'h11, 8'hC3, 8'hC3};
    tv[5] = '{1'b1, 8'h00, 8'hFF, 8'h12, 8'hC3};
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(exp_at(0, t0, 8'h00));
      @(negedge clk);
      chk($sformatf("idle_%0d", i));
    end
    foreach (tv[i]) run_txn(tv[i], 1);
    run_txn('{1'b1, 8'h7E, 8'h81, 8'h00, 8'hC3}, 5);
    run_b2b();
    run_reset_abort();
    run_txn('{1'b1, 8'h66, 8'h99, 8'h00, 8'h00}, 1);
    run_txn('{1'b0, 8'h33, 8'h00, 8'h6B, 8'h6B}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle generator for the RTC's multiplexed address/data parallel interface. It sits directly downstream of the RTC read/write sequencers. On request, it runs one complete register transaction: an address phase followed by a write-data or read-data phase. It drives A/D, CS, RD, WR and the shared AD bus, and reports which phase is active through the send_add / send_data / read_data flags that the sequencers decode.

## Interface
- T_SU, 2: setup cycles before each strobe, range 1..15
- T_PW, 8: strobe low width in cycles, range 1..15
- T_H, 2: hold cycles after each strobe, range 1..15; must be ≥2 when RTC_BUS_INSYNC_EN is defined
- T_REC, 11: recovery cycles after the data phase, range 1..15
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- do_it  in  1  transaction request; level-sensitive
- w_r  in  1  1 = write, 0 = read; latched at transaction start
- addr  in  8  RTC register address; latched at transaction start
- wdata  in  8  write data; latched at transaction start
- ad_in  in  8  AD bus input from pad
- ad_out  out  8  AD bus output to pad
- ad_oe  out  1  AD bus output enable
- a_d, cs, rd, wr  out  1 each  RTC control lines, active-low; idle level 1
- send_add  out  1  high throughout the address phase
- send_data  out  1  high throughout the data phase of a write
- read_data  out  1  high throughout the data phase of a read
- rdata  out  8  captured read data
- rdata_valid  out  1  one-cycle pulse when rdata is updated
- busy  out  1  high from ADR_SU through REC
- done  out  1  one-cycle pulse on the first REC cycle

## Operation
- States: IDLE, ADR_SU, ADR_PW, ADR_H, DAT_SU, DAT_PW, DAT_H, REC. Each non-IDLE state lasts exactly its parameter count (SU→T_SU, PW→T_PW, H→T_H, REC→T_REC).
- IDLE → ADR_SU when do_it=1; w_r, addr and wdata are latched on that edge.
- Last REC cycle: do_it=1 → ADR_SU (back-to-back, with a new latch); otherwise → IDLE.
- Falling do_it mid-transaction has no effect; the transaction always completes.
- Address phase (ADR_*):
  - a_d=0, ad_oe=1, ad_out=addr.
  - In ADR_PW only: cs=0, wr=0.
- Data phase, write (DAT_*):
  - a_d=1, ad_oe=1, ad_out=wdata.
  - In DAT_PW only: cs=0, wr=0.
- Data phase, read (DAT_*):
  - a_d=1, ad_oe=0, ad_out=0.
  - In DAT_PW only: cs=0, rd=0.
  - ad_in is captured into rdata on the last DAT_PW edge; rdata_valid is high the following cycle.
- REC and IDLE: a_d=cs=rd=wr=1, ad_oe=0, ad_out=0, all flags 0.
- rd and wr are never low simultaneously. cs is low only in ADR_PW and DAT_PW.
- rdata holds its value until the next capture.
- Reset values (all outputs registered): a_d=cs=rd=wr=1; ad_oe=0; ad_out=0; rdata=0; send_add=send_data=read_data=rdata_valid=busy=done=0; state=IDLE.
- Reset mid-transaction: the bus is released on the next edge. No rdata_valid or done pulse is issued for the aborted transaction.

## Timing
- All outputs are Moore, driven from flops, and valid in the first cycle of each state.
- Cycle numbering, with defaults; cycle 0 is the IDLE cycle in which do_it is sampled high:
  - ADR_SU: cycles 1–2
  - ADR_PW: cycles 3–10
  - ADR_H: cycles 11–12
  - DAT_SU: cycles 13–14
  - DAT_PW: cycles 15–22
  - DAT_H: cycles 23–24
  - REC: cycles 25–35
- done pulses in cycle 25.
- Read capture: on the cycle-22 edge; rdata_valid high in cycle 23.
- Back-to-back period: 3·T_SU + … is not the rule; the period is 2·(T_SU+T_PW+T_H)+T_REC = 35 cycles with do_it held high. This matches the sequencers' 35-cycle slot per register.
- Phase counter is 4 bits, loaded with (param−1) on state entry, and transitions at 0.

## Configuration
- Macro: RTC_BUS_INSYNC_EN.
- Defined:
  - ad_in passes through a 2-flop synchronizer.
  - Capture happens on the last DAT_H edge instead of DAT_PW (default: cycle-24 edge, rdata_valid in cycle 25, coincident with done).
- Undefined: no synchronizer; capture timing is as in Operation.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum;
  - default timing constants (2/8/2/11);
  - the idle levels of a_d/cs/rd/wr.
- One sub-module, rtc_phase_timer: 4-bit loadable down-counter with a terminal-count output. It is instantiated once and shared by all states.

## Test plan
- Reset, then idle 20 cycles → a_d=cs=rd=wr=1, ad_oe=0, all flags 0, busy=0.
- Write addr=0x21, wdata=0x45, one-cycle do_it:
  - cs low in cycles 3–10 and 15–22; wr low in the same cycles; rd stays 1.
  - ad_out=0x21 in cycles 1–12, 0x45 in cycles 13–24.
  - done in cycle 25; IDLE in cycle 36.
- Read addr=0x22, ad_in=0x59 during DAT_PW:
  - rd low in cycles 15–22, ad_oe=0 in cycles 13–24, read_data high in cycles 13–24.
  - rdata=0x59 with rdata_valid in cycle 23 (cycle 25 with RTC_BUS_INSYNC_EN defined).
- do_it held high for 10 writes → ADR_SU starts every 35 cycles with no IDLE gap; exactly 10 done pulses.
- Reset asserted in cycle 17 of a write → cs=wr=1 and ad_oe=0 from cycle 18; no done pulse; a new do_it starts a clean transaction.
- do_it dropped in cycle 5 → the transaction still completes; done in cycle 25; then IDLE.
